motor_pwm_array: RTL and testbench
==================================

Name: motor_pwm_array

Overview:
- Parametrised N-channel PWM generator for H-bridge motor drivers (L293-style EN/A/B per channel); successor to the fixed 2-channel motor controller.
- Shares one period counter across all channels.
- Applies new duty/direction commands glitch-free at period boundaries only.
- Inserts a dead-time coast interval whenever a channel reverses direction.
- Sits between the balance-control datapath (duty/sign commands) and the motor driver pins.

Parameters:
- N_CH, 2, number of motor channels.
- DUTY_W, 8, width of each channel's duty command.
- PERIOD, 200, PWM period in clk cycles; counter runs 0..PERIOD-1; must be >= 2 and <= 2**DUTY_W.
- DEADTIME_CYC, 4, clk cycles of forced coast on direction reversal; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  single-cycle strobe; captures duty_i/sign_i into the pending shadow.
- duty_i  input  N_CH*DUTY_W  per-channel duty, channel k at bits [k*DUTY_W +: DUTY_W].
- sign_i  input  N_CH  per-channel direction; 1 = forward.
- en_o  output  N_CH  PWM enable to driver EN pins.
- in_a_o  output  N_CH  driver input A.
- in_b_o  output  N_CH  driver input B.
- pending_o  output  1  high while a captured command awaits the next period boundary.
- period_start_o  output  1  one-cycle pulse in the cycle the counter equals 0.

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - counter = 0; pending = 0; pending_o = 0; period_start_o = 0.
  - All active duty = 0, active sign = 0.
  - en_o, in_a_o, in_b_o all 0.
  - Every channel in state COAST.
  - Reset asserted mid-period or mid-dead-time takes effect in the next cycle, unconditionally.
- Counter:
  - Increments each cycle; wraps from PERIOD-1 to 0.
  - period_start_o is registered, high in exactly the cycle where counter == 0.
- Shadow capture:
  - load high: pending regs <= duty_i/sign_i; pending <= 1.
  - A second load before the boundary overwrites the pending values (latest wins).
- Boundary apply (cycle where counter == PERIOD-1):
  - If pending (or load in this same cycle), the applied values are this cycle's inputs when load = 1, otherwise the pending regs.
  - Active regs update; pending clears (load in this cycle does not re-set it).
  - New values take effect from counter == 0.
- Duty arithmetic:
  - Compare is strict: en requested when counter < active_duty.
  - duty 0 gives an output that is always off.
  - duty >= PERIOD saturates to always on.
  - Compare width is max(DUTY_W, clog2(PERIOD)); no truncation.
- Per-channel FSM:
  - COAST: en = 0, A = 0, B = 0. The first boundary apply moves the channel to RUN, with the direction loaded and no dead-time.
  - RUN: en = PWM compare, A = sign, B = !sign. A boundary apply whose sign differs from the current sign moves the channel to DEAD and loads the timer with DEADTIME_CYC-1.
  - DEAD: en = 0, A = 0, B = 0; the timer decrements each cycle. At timer == 0 the channel moves to RUN with the new sign.
  - DEAD occupies exactly DEADTIME_CYC cycles, measured from counter == 0.
  - Duty updated during DEAD is retained and applies on return to RUN.
- Output timing:
  - All outputs are registered.
  - en_o at cycle t reflects counter/state of cycle t-1, i.e. 1-cycle latency from counter to pin.
- Same-sign boundary apply: duty changes seamlessly with no dead-time.
- DEADTIME_CYC >= PERIOD is legal: DEAD spans multiple periods, and further boundary applies during DEAD update duty/sign. A sign flip back to the original value still completes the dead-time.

Optional Feature:
- Macro MOTOR_PWM_BRAKE_EN.
- When defined:
  - Adds input brake_i [N_CH].
  - brake_i[k] high forces channel k to en = 1, A = 0, B = 0 (fast stop) from the next cycle.
  - Brake overrides RUN and DEAD; the DEAD timer keeps counting underneath.
  - On release, the channel resumes the outputs of its current state.
  - Reset clears brake effect.
- When undefined: no brake_i port, and behaviour is exactly as above.

Test Plan:
All scenarios use N_CH = 2, DUTY_W = 8, PERIOD = 10, DEADTIME_CYC = 3.
- Reset release, no load -> all en/A/B = 0 for 30 cycles; period_start_o pulses every 10 cycles.
- load duty = {3, 10}, sign = {1, 1} at counter = 4 -> pending_o = 1 until the boundary; from counter = 0: ch0 en high for 3 cycles per period, ch1 en always high; A = 1, B = 0.
- Two loads, duty 5 then duty 7, within one period -> only 7 applied; en high 7 of 10 cycles.
- In RUN with sign = 1, load sign = 0 with duty 5 -> at counter = 0, 3 cycles of en = A = B = 0, then A = 0, B = 1, en high for the remainder of counter < 5.
- load coincident with counter = 9 -> values applied at the immediately following counter = 0; pending_o stays 0.
- Reset asserted during DEAD, with MOTOR_PWM_BRAKE_EN defined and brake_i[0] = 1 -> the next cycle all outputs are 0 and the channel is in COAST; after release with brake_i[0] held, ch0 shows en = 1, A = B = 0.

Source files
------------

// File: rtl/motor_pwm_array.sv
// motor_pwm_array: N-channel H-bridge PWM generator (EN/A/B per channel).
// One shared period counter. Duty/direction commands are shadowed and applied
// only at the period boundary. A reversal inserts a forced-coast dead-time.
// Optional fast-stop brake input: define MOTOR_PWM_BRAKE_EN.

// Per-channel state machine, PWM compare and registered pin drivers.
module motor_pwm_ch #(
  parameter int DUTY_W       = 8,
  parameter int CNT_W        = 8,
  parameter int DEADTIME_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              apply,
  input  logic [DUTY_W-1:0] new_duty,
  input  logic              new_sign,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              brake,
  output logic              en_o,
  output logic              in_a_o,
  output logic              in_b_o
);
  localparam int TMR_W = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;

  typedef enum logic [1:0] {COAST, RUN, DEAD} ch_state_e;

  ch_state_e         state, state_nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic [DUTY_W-1:0] act_duty;
  logic              act_sign;
  logic              flip;

  // A reversal is judged against the direction currently held.
  assign flip = apply && (new_sign != act_sign);

  // State and dead-time timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COAST;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Next-state: COAST waits for the first command; a reversal routes through DEAD.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    case (state)
      COAST: if (apply) state_nxt = RUN;
      RUN: if (flip) begin
        state_nxt = DEAD;
        tmr_nxt   = TMR_W'(DEADTIME_CYC - 1);
      end
      DEAD: begin
        if (tmr == '0) begin
          // A fresh reversal landing exactly on expiry restarts the dead-time
          // rather than letting the bridge flip with no gap.
          if (flip) tmr_nxt = TMR_W'(DEADTIME_CYC - 1);
          else      state_nxt = RUN;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      default: state_nxt = COAST;
    endcase
  end

  // Active command registers; updated only by boundary applies, even in DEAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_duty <= '0;
      act_sign <= 1'b0;
    end else if (apply) begin
      act_duty <= new_duty;
      act_sign <= new_sign;
    end
  end

  // Registered pins; strict compare so duty 0 is off and duty >= PERIOD is on.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_o   <= 1'b0;
      in_a_o <= 1'b0;
      in_b_o <= 1'b0;
    end else if (brake) begin
      en_o   <= 1'b1;
      in_a_o <= 1'b0;
      in_b_o <= 1'b0;
    end else if (state == RUN) begin
      en_o   <= (cnt < CNT_W'(act_duty));
      in_a_o <= act_sign;
      in_b_o <= !act_sign;
    end else begin
      en_o   <= 1'b0;
      in_a_o <= 1'b0;
      in_b_o <= 1'b0;
    end
  end
endmodule

// Top: shared counter, command shadow and the channel array.
module motor_pwm_array #(
  parameter int N_CH         = 2,
  parameter int DUTY_W       = 8,
  parameter int PERIOD       = 200,
  parameter int DEADTIME_CYC = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [N_CH*DUTY_W-1:0]   duty_i,
  input  logic [N_CH-1:0]          sign_i,
`ifdef MOTOR_PWM_BRAKE_EN
  input  logic [N_CH-1:0]          brake_i,
`endif
  output logic [N_CH-1:0]          en_o,
  output logic [N_CH-1:0]          in_a_o,
  output logic [N_CH-1:0]          in_b_o,
  output logic                     pending_o,
  output logic                     period_start_o
);
  // Wide enough for both the counter range and any duty value.
  localparam int CNT_W = ($clog2(PERIOD) > DUTY_W) ? $clog2(PERIOD) : DUTY_W;

  logic [CNT_W-1:0]             cnt;
  logic                         at_end, apply;
  logic [N_CH-1:0][DUTY_W-1:0]  duty_v, pend_duty, app_duty;
  logic [N_CH-1:0]              pend_sign, app_sign, brake_v;

  assign duty_v = duty_i;
  assign at_end = (cnt == CNT_W'(PERIOD - 1));
  // A load in the boundary cycle itself bypasses the shadow.
  assign apply    = at_end && (pending_o || load);
  assign app_duty = load ? duty_v : pend_duty;
  assign app_sign = load ? sign_i : pend_sign;

`ifdef MOTOR_PWM_BRAKE_EN
  assign brake_v = brake_i;
`else
  assign brake_v = '0;
`endif

  // Free-running period counter; period_start_o lands in the counter==0 cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      period_start_o <= 1'b0;
    end else begin
      cnt            <= at_end ? '0 : cnt + CNT_W'(1);
      period_start_o <= at_end;
    end
  end

  // Command shadow; latest load wins, boundary consumes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_o <= 1'b0;
      pend_duty <= '0;
      pend_sign <= '0;
    end else begin
      if (load) begin
        pend_duty <= duty_v;
        pend_sign <= sign_i;
      end
      if (at_end)    pending_o <= 1'b0;
      else if (load) pending_o <= 1'b1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    motor_pwm_ch #(
      .DUTY_W      (DUTY_W),
      .CNT_W       (CNT_W),
      .DEADTIME_CYC(DEADTIME_CYC)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .apply   (apply),
      .new_duty(app_duty[k]),
      .new_sign(app_sign[k]),
      .cnt     (cnt),
      .brake   (brake_v[k]),
      .en_o    (en_o[k]),
      .in_a_o  (in_a_o[k]),
      .in_b_o  (in_b_o[k])
    );
  end
endmodule

// File: tb/tb_motor_pwm_array.sv
// Directed bench for motor_pwm_array (N_CH=2, DUTY_W=8, PERIOD=10, DEADTIME_CYC=3).
// Expected pin words are queued per cycle and popped as the DUT produces them.
module tb_motor_pwm_array;
  localparam int N_CH = 2, DUTY_W = 8, PERIOD = 10, DT = 3;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   load = 1'b0;
  logic [N_CH*DUTY_W-1:0] duty_i = '0;
  logic [N_CH-1:0]        sign_i = '0;
  logic [N_CH-1:0]        brake_i = '0;
  logic [N_CH-1:0]        en_o, in_a_o, in_b_o;
  logic                   pending_o, period_start_o;

  motor_pwm_array #(.N_CH(N_CH), .DUTY_W(DUTY_W), .PERIOD(PERIOD), .DEADTIME_CYC(DT)) dut (
    .clk(clk), .reset(reset), .load(load), .duty_i(duty_i), .sign_i(sign_i),
`ifdef MOTOR_PWM_BRAKE_EN
    .brake_i(brake_i),
`endif
    .en_o(en_o), .in_a_o(in_a_o), .in_b_o(in_b_o),
    .pending_o(pending_o), .period_start_o(period_start_o));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] v; string tag; } exp_t;
  exp_t q[$];
  int   checks = 0, errors = 0;
  int   ph = 0;  // counter value the DUT holds in the current cycle

  // Observed word: {period_start, pending, b[1:0], a[1:0], en[1:0]}.
  function automatic logic [7:0] obs_word();
    return {period_start_o, pending_o, in_b_o, in_a_o, en_o};
  endfunction

  // Pins for one channel in a cycle whose counter is p; they reflect cycle p-1.
  // mode: 0 = outputs off (COAST/DEAD), 1 = RUN, 2 = brake.
  function automatic logic [2:0] pins(int p, int mode, int d, bit s);
    int prev = (p + PERIOD - 1) % PERIOD;
    if (mode == 2) return 3'b001;
    if (mode == 1) return {!s, s, (prev < d)};
    return 3'b000;
  endfunction

  task automatic tick();
    @(posedge clk);
    ph = (ph + 1) % PERIOD;
    #1;
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Queue n cycles of expectation with fixed per-channel config, then drain them.
  task automatic seg(string tag, int n, bit pend,
                     int m0, int d0, bit s0, int m1, int d1, bit s1);
    for (int i = 1; i <= n; i++) begin
      int p = (ph + i) % PERIOD;
      logic [2:0] c0 = pins(p, m0, d0, s0);
      logic [2:0] c1 = pins(p, m1, d1, s1);
      exp_t e;
      e.v   = {(p == 0), pend, c1[2], c0[2], c1[1], c0[1], c1[0], c0[0]};
      e.tag = $sformatf("%s@cnt%0d", tag, p);
      q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      exp_t e;
      tick();
      e = q.pop_front();
      chk(e.tag, obs_word(), e.v);
    end
  endtask

  task automatic cmd(int d0, int d1, logic [1:0] s);
    load   = 1'b1;
    duty_i = {8'(d1), 8'(d0)};
    sign_i = s;
  endtask

  initial begin
    // Reset: everything low, counter parked at 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset", obs_word(), 8'h00);
    end
    ph = 0;
    reset = 1'b0;
    // Idle 30 cycles: pins off, period_start every 10 cycles.
    seg("idle", 30, 0, 0, 0, 0, 0, 0, 0);

    // Load {3,10} fwd at counter 4; pending until the boundary.
    seg("pre1", 4, 0, 0, 0, 0, 0, 0, 0);
    cmd(3, 10, 2'b11);
    seg("pend1", 1, 1, 0, 0, 0, 0, 0, 0);
    load = 1'b0;
    seg("pend1", 4, 1, 0, 0, 0, 0, 0, 0);
    seg("bnd1", 1, 0, 0, 0, 0, 0, 0, 0);
    seg("run1", 20, 0, 1, 3, 1, 1, 10, 1);

    // Two loads in one period: only the second (duty 7) survives.
    seg("run1b", 2, 0, 1, 3, 1, 1, 10, 1);
    cmd(5, 10, 2'b11);
    seg("ld5", 1, 1, 1, 3, 1, 1, 10, 1);
    load = 1'b0;
    seg("ld5w", 3, 1, 1, 3, 1, 1, 10, 1);
    cmd(7, 10, 2'b11);
    seg("ld7", 1, 1, 1, 3, 1, 1, 10, 1);
    load = 1'b0;
    seg("ld7w", 2, 1, 1, 3, 1, 1, 10, 1);
    seg("bnd2", 1, 0, 1, 3, 1, 1, 10, 1);
    seg("run7", 10, 0, 1, 7, 1, 1, 10, 1);

    // Reverse ch0 (duty 5); ch1 same sign continues seamlessly.
    seg("run7b", 5, 0, 1, 7, 1, 1, 10, 1);
    cmd(5, 10, 2'b10);
    seg("rev", 1, 1, 1, 7, 1, 1, 10, 1);
    load = 1'b0;
    seg("revw", 3, 1, 1, 7, 1, 1, 10, 1);
    seg("bnd3", 1, 0, 1, 7, 1, 1, 10, 1);
    seg("dead", DT, 0, 0, 0, 0, 1, 10, 1);
    seg("rev_run", 7, 0, 1, 5, 0, 1, 10, 1);
    seg("rev_run2", 10, 0, 1, 5, 0, 1, 10, 1);

    // Load coincident with counter 9: applied immediately, pending stays low.
    seg("pre9", 9, 0, 1, 5, 0, 1, 10, 1);
    cmd(2, 4, 2'b10);
    seg("ld9", 1, 0, 1, 5, 0, 1, 10, 1);
    load = 1'b0;
    seg("run24", 10, 0, 1, 2, 0, 1, 4, 1);

    // Duty extremes: 0 never on, 255 (>= PERIOD) always on.
    seg("pre_ext", 3, 0, 1, 2, 0, 1, 4, 1);
    cmd(0, 255, 2'b10);
    seg("ext_p", 1, 1, 1, 2, 0, 1, 4, 1);
    load = 1'b0;
    seg("ext_w", 5, 1, 1, 2, 0, 1, 4, 1);
    seg("bnd5", 1, 0, 1, 2, 0, 1, 4, 1);
    seg("ext", 10, 0, 1, 0, 0, 1, 255, 1);

    // Reverse ch0 again, then reset while it sits in DEAD.
    seg("pre6", 4, 0, 1, 0, 0, 1, 255, 1);
    cmd(5, 255, 2'b11);
    seg("rev6", 1, 1, 1, 0, 0, 1, 255, 1);
    load = 1'b0;
    seg("rev6w", 4, 1, 1, 0, 0, 1, 255, 1);
    seg("bnd6", 1, 0, 1, 0, 0, 1, 255, 1);
    seg("dead6", 1, 0, 0, 0, 0, 1, 255, 1);
    reset = 1'b1;
    brake_i = 2'b01;
    tick();
    chk("rst_dead", obs_word(), 8'h00);
    tick();
    chk("rst_dead2", obs_word(), 8'h00);
    ph = 0;
    reset = 1'b0;
`ifdef MOTOR_PWM_BRAKE_EN
    seg("brake", 12, 0, 2, 0, 0, 0, 0, 0);
    brake_i = 2'b00;
    seg("unbrake", 8, 0, 0, 0, 0, 0, 0, 0);
`else
    seg("coast", 20, 0, 0, 0, 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
